icsp_phy: RTL

//   Bit-level PIC24 ICSP engine inside fpga_top. Accepts one command at a time

---
 rtl/icsp_phy.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/icsp_phy.sv
// PIC24 ICSP bit engine: runs one SIX / REGOUT / ENTER / EXIT command at a time,
// generating PGCx, driving or releasing PGDx, and controlling MCLRn.
module icsp_phy #(
    parameter int unsigned HALF_PER  = 4,
    parameter int unsigned T_MCLR    = 50,
    parameter int unsigned T_ENTRY   = 100,
    parameter logic [31:0] ENTRY_KEY = 32'h4D434851
) (
    input  logic        clk50MHz,
    input  logic        rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic [23:0] cmd_data,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        busy,
    output logic        PGCx,
    output logic        PGDx_out,
    output logic        PGDx_dir,
    input  logic        PGDx_in,
    output logic        MCLRn
);

    localparam logic [1:0] CmdSix    = 2'b00;
    localparam logic [1:0] CmdRegout = 2'b01;
    localparam logic [1:0] CmdEnter  = 2'b10;
    localparam logic [1:0] CmdExit   = 2'b11;

    localparam int unsigned CntMax = (HALF_PER > T_MCLR) ?
        ((HALF_PER > T_ENTRY) ? HALF_PER : T_ENTRY) :
        ((T_MCLR > T_ENTRY) ? T_MCLR : T_ENTRY);
    localparam int unsigned CntW = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [CntW-1:0] HalfLast  = CntW'(HALF_PER - 1);
    localparam logic [CntW-1:0] MclrLast  = CntW'(T_MCLR - 1);
    localparam logic [CntW-1:0] EntryLast = CntW'(T_ENTRY - 1);

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    // The shifter always emits bit 0 first, so the MSb-first key is stored reversed.
    localparam logic [31:0] KeyRev = rev32(ENTRY_KEY);

    typedef enum logic [3:0] {
        StIdle,
        StMclrLo,
        StKey,
        StMclrHiWait,
        StEntryWait,
        StShift,
        StGap,
        StRead,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [5:0]      bit_q, bit_d;
    logic [1:0]      type_q, type_d;
    logic [31:0]     sh_q, sh_d;
    logic [15:0]     rsh_q, rsh_d;
    logic            pgc_q, pgc_d;
    logic            pgd_q, pgd_d;
    logic            dir_q, dir_d;
    logic            mclr_q, mclr_d;
    logic [15:0]     rd_data_q, rd_data_d;
    logic            rd_valid_q, rd_valid_d;

    logic            half_end;
    logic            cell_end;
    logic [CntW-1:0] cell_cnt;
    logic            cell_pgc;
    logic [5:0]      shift_last;

    always_ff @(posedge clk50MHz) begin
        if (!rstn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            type_q     <= CmdSix;
            sh_q       <= '0;
            rsh_q      <= '0;
            pgc_q      <= 1'b0;
            pgd_q      <= 1'b0;
            dir_q      <= 1'b0;
            mclr_q     <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            type_q     <= type_d;
            sh_q       <= sh_d;
            rsh_q      <= rsh_d;
            pgc_q      <= pgc_d;
            pgd_q      <= pgd_d;
            dir_q      <= dir_d;
            mclr_q     <= mclr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        type_d     = type_q;
        sh_d       = sh_q;
        rsh_d      = rsh_q;
        pgc_d      = pgc_q;
        mclr_d     = mclr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        // Each PGC half-phase lasts HALF_PER cycles; a cell ends on the last high cycle.
        half_end   = (cnt_q == HalfLast);
        cell_end   = pgc_q && half_end;
        cell_cnt   = half_end ? '0 : cnt_q + CntW'(1);
        cell_pgc   = pgc_q ^ half_end;
        shift_last = (type_q == CmdSix) ? 6'd27 : 6'd3;

        case (state_q)
            StIdle: begin
                pgc_d = 1'b0;
                if (cmd_valid) begin
                    type_d = cmd_type;
                    cnt_d  = '0;
                    bit_d  = '0;
                    case (cmd_type)
                        CmdSix: begin
                            sh_d    = {4'b0000, cmd_data, 4'b0000};
                            state_d = StShift;
                        end
                        CmdRegout: begin
                            sh_d    = 32'h0000_0001;
                            state_d = StShift;
                        end
                        CmdEnter: begin
                            sh_d    = KeyRev;
                            mclr_d  = 1'b0;
                            state_d = StMclrLo;
                        end
                        CmdExit: begin
                            mclr_d  = 1'b0;
                            state_d = StMclrLo;
                        end
                        default: state_d = StIdle;
                    endcase
                end
            end

            StMclrLo: begin
                if (cnt_q == MclrLast) begin
                    cnt_d = '0;
                    if (type_q == CmdEnter) begin
                        state_d = StKey;
                    end else begin
                        mclr_d  = 1'b1;
                        state_d = StDone;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StKey: begin
                cnt_d = cell_cnt;
                pgc_d = cell_pgc;
                if (cell_end) begin
                    sh_d  = sh_q >> 1;
                    bit_d = bit_q + 6'd1;
                    if (bit_q == 6'd31) begin
                        bit_d   = '0;
                        state_d = StMclrHiWait;
                    end
                end
            end

            StMclrHiWait: begin
                if (cnt_q == MclrLast) begin
                    cnt_d   = '0;
                    mclr_d  = 1'b1;
                    state_d = StEntryWait;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StEntryWait: begin
                if (cnt_q == EntryLast) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StShift: begin
                cnt_d = cell_cnt;
                pgc_d = cell_pgc;
                if (cell_end) begin
                    sh_d  = sh_q >> 1;
                    bit_d = bit_q + 6'd1;
                    if (bit_q == shift_last) begin
                        bit_d   = '0;
                        state_d = (type_q == CmdSix) ? StDone : StGap;
                    end
                end
            end

            StGap: begin
                cnt_d = cell_cnt;
                pgc_d = cell_pgc;
                if (cell_end) begin
                    bit_d = bit_q + 6'd1;
                    if (bit_q == 6'd7) begin
                        bit_d   = '0;
                        state_d = StRead;
                    end
                end
            end

            StRead: begin
                cnt_d = cell_cnt;
                pgc_d = cell_pgc;
                // Sample on the first high cycle of each cell.
                if (pgc_q && (cnt_q == '0)) begin
                    rsh_d = {PGDx_in, rsh_q[15:1]};
                end
                if (cell_end) begin
                    bit_d = bit_q + 6'd1;
                    if (bit_q == 6'd15) begin
                        bit_d      = '0;
                        rd_data_d  = rsh_q;
                        rd_valid_d = 1'b1;
                        state_d    = StDone;
                    end
                end
            end

            StDone: begin
                cnt_d   = '0;
                pgc_d   = 1'b0;
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase

        // Data only changes when a new cell starts, since sh_d only moves at cell ends.
        pgd_d = ((state_d == StShift) || (state_d == StKey)) ? sh_d[0] : 1'b0;
        dir_d = (state_d == StGap) || (state_d == StRead);
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = ~cmd_ready;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign PGCx      = pgc_q;
    assign PGDx_out  = pgd_q;
    assign PGDx_dir  = dir_q;
    assign MCLRn     = mclr_q;

endmodule
